fetch_redirect_unit: RTL and testbench

//  IF-stage PC owner and consumer of the MEM-stage branch decision (cntrl_branch + target).

---
 rtl/fetch_redirect_unit_pkg.sv | 20 ++
 rtl/fetch_redirect_unit.sv | 99 +++++++++
 tb/tb_fetch_redirect_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_redirect_unit_pkg : shared fetch/halt types and defaults        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fetch_redirect_unit_pkg;

   localparam int          c_PC_W         = 16;
   localparam logic [15:0] c_RESET_VECTOR = 16'h0000;
   // Pipeline distance from ID to MEM; older branches resolve within this window.
   localparam int          c_DRAIN_CYCLES = 2;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HALTING = 2'd1,
      ST_HALTED  = 2'd2
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_redirect_unit : IF-stage PC owner, branch redirect and halt FSM |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_redirect_unit
   import fetch_redirect_unit_pkg::*;
#(
   parameter int              PC_W         = c_PC_W,
   parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(c_RESET_VECTOR),
   parameter int              DRAIN_CYCLES = c_DRAIN_CYCLES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hlt,
   input  logic            stall,
   input  logic            cntrl_branch,
   input  logic [PC_W-1:0] MEM_branch_tgt,
   output logic [PC_W-1:0] IF_pc,
   output logic [PC_W-1:0] IF_pc_plus1,
   output logic            imem_re,
   output logic            flush_IF_ID,
   output logic            flush_ID_EX,
   output logic            flush_EX_MEM,
   output logic            halted
);

   localparam int                   c_DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam logic [c_DRAIN_W-1:0] c_DRAIN_INIT = c_DRAIN_W'(DRAIN_CYCLES);
   localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);

   fetch_state_e         r_state;
   logic [PC_W-1:0]      r_pc;
   logic [c_DRAIN_W-1:0] r_drain_cnt;
   logic                 r_halted;
   logic                 w_redirect;

   // A halted core ignores late branches: they belong to instructions behind the halt.
   assign w_redirect = cntrl_branch && (r_state != ST_HALTED);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_pc        <= RESET_VECTOR;
         r_drain_cnt <= '0;
         r_halted    <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (cntrl_branch) begin
                  r_pc <= MEM_branch_tgt;
               end else if (stall) begin
                  r_pc <= r_pc;
               end else if (hlt) begin
                  if (DRAIN_CYCLES == 0) begin
                     r_state  <= ST_HALTED;
                     r_halted <= 1'b1;
                  end else begin
                     r_state     <= ST_HALTING;
                     r_drain_cnt <= c_DRAIN_INIT;
                  end
               end else begin
                  r_pc <= r_pc + PC_W'(1);
               end
            end
            ST_HALTING: begin
               if (cntrl_branch) begin
                  r_pc        <= MEM_branch_tgt;
                  r_drain_cnt <= '0;
                  r_state     <= ST_RUN;
               end else if (r_drain_cnt <= c_DRAIN_ONE) begin
                  r_drain_cnt <= '0;
                  r_state     <= ST_HALTED;
                  r_halted    <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt - c_DRAIN_ONE;
               end
            end
            ST_HALTED: begin
               r_halted <= 1'b1;
            end
            default: begin
               r_state     <= ST_RUN;
               r_drain_cnt <= '0;
            end
         endcase
      end
   end

   assign IF_pc        = r_pc;
   assign IF_pc_plus1  = r_pc + PC_W'(1);
   assign imem_re      = !rst && (r_state == ST_RUN);
   assign flush_IF_ID  = !rst && w_redirect;
   assign flush_ID_EX  = !rst && w_redirect;
   assign flush_EX_MEM = !rst && w_redirect;
   assign halted       = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_redirect_unit : directed scoreboard bench for fetch unit    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fetch_redirect_unit;

   logic        clk;
   logic        rst;
   logic        hlt;
   logic        stall;
   logic        cntrl_branch;
   logic [15:0] MEM_branch_tgt;
   logic [15:0] IF_pc;
   logic [15:0] IF_pc_plus1;
   logic        imem_re;
   logic        flush_IF_ID;
   logic        flush_ID_EX;
   logic        flush_EX_MEM;
   logic        halted;

   typedef struct {
      string       name;
      logic [15:0] pc;
      logic        re;
      logic        fl;
      logic        hal;
   } exp_t;

   exp_t q_exp[$];
   int   n_pass;
   int   n_total;

   fetch_redirect_unit #(
      .PC_W         (16),
      .RESET_VECTOR (16'h0000),
      .DRAIN_CYCLES (2)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .hlt            (hlt),
      .stall          (stall),
      .cntrl_branch   (cntrl_branch),
      .MEM_branch_tgt (MEM_branch_tgt),
      .IF_pc          (IF_pc),
      .IF_pc_plus1    (IF_pc_plus1),
      .imem_re        (imem_re),
      .flush_IF_ID    (flush_IF_ID),
      .flush_ID_EX    (flush_ID_EX),
      .flush_EX_MEM   (flush_EX_MEM),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the edge and queue the outputs expected for that cycle.
   task automatic step(input string nm, input logic r, input logic h, input logic s,
                       input logic b, input logic [15:0] tgt,
                       input logic [15:0] e_pc, input logic e_re, input logic e_fl, input logic e_hal);
      exp_t e;
      @(posedge clk);
      #1;
      rst            = r;
      hlt            = h;
      stall          = s;
      cntrl_branch   = b;
      MEM_branch_tgt = tgt;
      e.name = nm;
      e.pc   = e_pc;
      e.re   = e_re;
      e.fl   = e_fl;
      e.hal  = e_hal;
      q_exp.push_back(e);
   endtask

   // Monitor: compare mid-cycle whenever an expectation is pending.
   initial begin
      forever begin
         @(negedge clk);
         if (q_exp.size() > 0) begin
            exp_t        e;
            logic [15:0] e_p1;
            e    = q_exp.pop_front();
            e_p1 = e.pc + 16'd1;
            n_total++;
            if (IF_pc === e.pc && IF_pc_plus1 === e_p1 && imem_re === e.re &&
                flush_IF_ID === e.fl && flush_ID_EX === e.fl && flush_EX_MEM === e.fl &&
                halted === e.hal) begin
               n_pass++;
            end else begin
               $display("FAIL %s: got pc=%h p1=%h re=%b fl=%b%b%b hal=%b, want pc=%h p1=%h re=%b fl=%b hal=%b",
                        e.name, IF_pc, IF_pc_plus1, imem_re, flush_IF_ID, flush_ID_EX, flush_EX_MEM,
                        halted, e.pc, e_p1, e.re, e.fl, e.hal);
            end
         end
      end
   end

   initial begin
      n_pass         = 0;
      n_total        = 0;
      rst            = 1'b1;
      hlt            = 1'b0;
      stall          = 1'b0;
      cntrl_branch   = 1'b0;
      MEM_branch_tgt = 16'h0000;
      repeat (2) @(posedge clk);

      //    name           rst  hlt  stl  br   tgt       pc        re   fl   hal
      step("rst_gate",     1,   0,   0,   1,   16'h0055, 16'h0000, 0,   0,   0);
      step("free0",        0,   0,   0,   0,   16'h0000, 16'h0000, 1,   0,   0);
      step("free1",        0,   0,   0,   0,   16'h0000, 16'h0001, 1,   0,   0);
      step("free2",        0,   0,   0,   0,   16'h0000, 16'h0002, 1,   0,   0);
      step("free3",        0,   0,   0,   0,   16'h0000, 16'h0003, 1,   0,   0);
      step("free4",        0,   0,   0,   0,   16'h0000, 16'h0004, 1,   0,   0);
      step("br_to_10",     0,   0,   0,   1,   16'h0010, 16'h0005, 1,   1,   0);
      step("br_to_200",    0,   0,   0,   1,   16'h0200, 16'h0010, 1,   1,   0);
      step("stall_hold",   0,   0,   1,   0,   16'h0000, 16'h0200, 1,   0,   0);
      step("after_stall",  0,   0,   0,   0,   16'h0000, 16'h0200, 1,   0,   0);
      step("br_stl_hlt",   0,   1,   1,   1,   16'h0300, 16'h0201, 1,   1,   0);
      step("post_br_run",  0,   0,   0,   0,   16'h0000, 16'h0300, 1,   0,   0);
      step("br_to_20a",    0,   0,   0,   1,   16'h0020, 16'h0301, 1,   1,   0);
      step("hlt_cancel",   0,   1,   0,   0,   16'h0000, 16'h0020, 1,   0,   0);
      step("halting_br",   0,   0,   0,   1,   16'h0100, 16'h0020, 0,   1,   0);
      step("cancel_run0",  0,   0,   0,   0,   16'h0000, 16'h0100, 1,   0,   0);
      step("cancel_run1",  0,   0,   0,   0,   16'h0000, 16'h0101, 1,   0,   0);
      step("br_to_20b",    0,   0,   0,   1,   16'h0020, 16'h0102, 1,   1,   0);
      step("hlt_seen",     0,   1,   0,   0,   16'h0000, 16'h0020, 1,   0,   0);
      step("drain1",       0,   1,   1,   0,   16'h0000, 16'h0020, 0,   0,   0);
      step("drain2",       0,   0,   0,   0,   16'h0000, 16'h0020, 0,   0,   0);
      step("halted_br",    0,   0,   0,   1,   16'h0077, 16'h0020, 0,   0,   1);
      step("halted_idle",  0,   0,   0,   0,   16'h0000, 16'h0020, 0,   0,   1);
      step("halted_hlt",   0,   1,   1,   0,   16'h0000, 16'h0020, 0,   0,   1);
      step("rst_halted",   1,   0,   0,   0,   16'h0000, 16'h0020, 0,   0,   1);
      step("br_to_fffe",   0,   0,   0,   1,   16'hFFFE, 16'h0000, 1,   1,   0);
      step("pc_fffe",      0,   0,   0,   0,   16'h0000, 16'hFFFE, 1,   0,   0);
      step("pc_ffff",      0,   0,   0,   0,   16'h0000, 16'hFFFF, 1,   0,   0);
      step("wrap_0",       0,   0,   0,   0,   16'h0000, 16'h0000, 1,   0,   0);
      step("wrap_1",       0,   0,   0,   0,   16'h0000, 16'h0001, 1,   0,   0);
      step("hlt_again",    0,   1,   0,   0,   16'h0000, 16'h0002, 1,   0,   0);
      step("rst_halting",  1,   0,   0,   1,   16'h0099, 16'h0002, 0,   0,   0);
      step("post_rst0",    0,   0,   0,   0,   16'h0000, 16'h0000, 1,   0,   0);
      step("post_rst1",    0,   0,   0,   0,   16'h0000, 16'h0001, 1,   0,   0);

      for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clk);
      if (q_exp.size() > 0) begin
         n_total++;
         $display("FAIL drain_queue: %0d expectations left, want 0", q_exp.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
